// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared word codes, markers, FSM encoding and the header
//               helper for the TDC event packer.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

  localparam logic [3:0]  c_type_tdc_hdr = 4'b0001;
  localparam logic [3:0]  c_type_tdc_trl = 4'b0011;
  localparam logic [3:0]  c_type_lead    = 4'b0100;
  localparam logic [3:0]  c_type_trail   = 4'b0101;
  localparam logic [3:0]  c_type_err     = 4'b0110;

  localparam logic [3:0]  c_hdr_marker   = 4'hA;
  localparam logic [3:0]  c_trl_marker   = 4'h5;
  localparam logic [31:0] c_pad_word     = 32'hFFFF_FFFF;

  localparam int          c_err_tdc      = 0;
  localparam int          c_err_unknown  = 1;
  localparam int          c_err_trunc    = 2;

  localparam logic [15:0] c_crc_init     = 16'hFFFF;
  localparam logic [15:0] c_crc_poly     = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_FETCH   = 3'd2,
    S_PACK    = 3'd3,
    S_TRAILER = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic [63:0] make_header(
    input logic [3:0]  trig,
    input logic [23:0] lv1,
    input logic [11:0] bx,
    input logic [11:0] fec,
    input logic [3:0]  fov
  );
    return {c_hdr_marker, trig, lv1, bx, fec, fov, 1'b0, 1'b0, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_event_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : tdc_event_packer_if
// Description : Request, FIFO-side and output-stream signals of the packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdc_event_packer_if;

  logic        transmit_request;
  logic [31:0] orbit_number;
  logic [31:0] acquisition_counter;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_data;
  logic [63:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        transmit_complete;
  logic        busy;
  logic [14:0] err_flags;

  // master: the packer itself
  modport master (
    input  transmit_request, orbit_number, acquisition_counter,
    input  fifo_empty, fifo_data, data_ready,
    output fifo_rd_en, data_out, data_valid, transmit_complete, busy, err_flags
  );

  modport slave (
    output transmit_request, orbit_number, acquisition_counter,
    output fifo_empty, fifo_data, data_ready,
    input  fifo_rd_en, data_out, data_valid, transmit_complete, busy, err_flags
  );

endinterface
`default_nettype wire

// File: rtl/crc16_64.sv
`default_nettype none
// ============================================================================
// Module      : crc16_64
// Description : CRC-16-CCITT (0x1021, init 0xFFFF), one 64-bit word per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module crc16_64
  import tdc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [63:0] i_data,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // MSB-first, non-reflected
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [63:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 63; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? c_crc_poly : 16'h0000);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= c_crc_init;
    end else if (i_en) begin
      r_crc <= crc_step(i_clear ? c_crc_init : r_crc, i_data);
    end else if (i_clear) begin
      r_crc <= c_crc_init;
    end
  end

  assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/tdc_event_packer.sv
`default_nettype none
// ============================================================================
// Module      : tdc_event_packer
// Description : Packs HPTDC FIFO words into a header/payload/trailer 64-bit
//               stream. TDC_EVENT_PACKER_CRC_EN adds a CRC-16 in the trailer.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_event_packer
  import tdc_pkg::*;
#(
  parameter logic [3:0]  TRIGGER_TYPE = 4'hA,
  parameter logic [11:0] FEC_ID       = 12'd10,
  parameter logic [3:0]  FOV          = 4'd2,
  parameter int          NUM_TDC      = 4,
  parameter int          MAX_WORDS    = 1024,
  parameter int          CNT_W        = 12
) (
  input  logic                clk,
  input  logic                rst,
  tdc_event_packer_if.master  io_bus
);

  localparam int                TDC_W       = $clog2(NUM_TDC + 1);
  localparam logic [TDC_W-1:0]  c_last_tdc  = TDC_W'(NUM_TDC - 1);
  localparam logic [CNT_W-1:0]  c_max_words = CNT_W'(MAX_WORDS);

  state_t             r_state;
  logic [63:0]        r_data_out;
  logic               r_valid;
  logic               r_rd_en;
  logic               r_pending;
  logic               r_complete;
  logic               r_busy;
  logic [31:0]        r_half;
  logic               r_half_vld;
  logic [TDC_W-1:0]   r_tdc_done;
  logic [CNT_W-1:0]   r_evt_len;
  logic [CNT_W-1:0]   r_hit_cnt;
  logic [2:0]         r_err;
  logic [14:0]        r_err_flags;

  logic [3:0]         w_type;
  logic               w_is_hit;
  logic               w_accept;
  logic [CNT_W-1:0]   w_evt_next;
  logic [15:0]        w_crc;
  logic [63:0]        w_trailer;

  assign w_type     = io_bus.fifo_data[31:28];
  assign w_is_hit   = (w_type == c_type_lead) || (w_type == c_type_trail) || (w_type == c_type_err);
  assign w_accept   = r_valid & io_bus.data_ready;
  assign w_evt_next = (r_evt_len == '1) ? r_evt_len : r_evt_len + CNT_W'(1);
  // evt_len counts words loaded so far, so w_evt_next already includes the trailer
  assign w_trailer  = {c_trl_marker, 4'h0, 24'(w_evt_next), 1'b0, r_err,
                       12'(r_hit_cnt), w_crc};

`ifdef TDC_EVENT_PACKER_CRC_EN
  logic r_valid_d;
  logic w_crc_en;
  logic w_crc_clr;

  always_ff @(posedge clk) begin
    if (rst) r_valid_d <= 1'b0;
    else     r_valid_d <= r_valid;
  end

  // Each word is folded in on its first valid cycle; the trailer is excluded
  assign w_crc_en  = r_valid & ~r_valid_d & ~((r_state == S_TRAILER) & ~r_half_vld);
  assign w_crc_clr = (r_state == S_HEADER);

  crc16_64 u_crc (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_crc_clr),
    .i_en    (w_crc_en),
    .i_data  (r_data_out),
    .o_crc   (w_crc)
  );
`else
  assign w_crc = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_pending   <= 1'b0;
      r_complete  <= 1'b0;
      r_busy      <= 1'b0;
      r_half      <= '0;
      r_half_vld  <= 1'b0;
      r_tdc_done  <= '0;
      r_evt_len   <= '0;
      r_hit_cnt   <= '0;
      r_err       <= '0;
      r_err_flags <= '0;
    end else begin
      r_complete <= 1'b0;
      r_rd_en    <= 1'b0;
      r_pending  <= r_rd_en;
      case (r_state)
        S_IDLE: begin
          if (io_bus.transmit_request) begin
            r_data_out  <= make_header(TRIGGER_TYPE, io_bus.acquisition_counter[23:0],
                                       io_bus.orbit_number[11:0], FEC_ID, FOV);
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_evt_len   <= CNT_W'(1);
            r_hit_cnt   <= '0;
            r_tdc_done  <= '0;
            r_err       <= '0;
            r_err_flags <= '0;
            r_half_vld  <= 1'b0;
            r_state     <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!io_bus.fifo_empty && !r_rd_en && !r_pending) r_rd_en <= 1'b1;
          if (r_pending) begin
            if (w_is_hit) begin
              if (w_type == c_type_err) begin
                r_err[c_err_tdc] <= 1'b1;
                r_err_flags      <= r_err_flags | io_bus.fifo_data[14:0];
              end
              if (r_hit_cnt == c_max_words) begin
                r_err[c_err_trunc] <= 1'b1;
              end else begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                if (r_half_vld) begin
                  r_data_out <= {r_half, io_bus.fifo_data};
                  r_valid    <= 1'b1;
                  r_half_vld <= 1'b0;
                  r_evt_len  <= w_evt_next;
                  r_state    <= S_PACK;
                end else begin
                  r_half     <= io_bus.fifo_data;
                  r_half_vld <= 1'b1;
                end
              end
            end else if (w_type == c_type_tdc_trl) begin
              if (r_tdc_done == c_last_tdc) begin
                r_state <= S_TRAILER;
                if (r_half_vld) begin
                  r_data_out <= {r_half, c_pad_word};
                  r_valid    <= 1'b1;
                  r_evt_len  <= w_evt_next;
                end
              end else begin
                r_tdc_done <= r_tdc_done + TDC_W'(1);
              end
            end else if (w_type != c_type_tdc_hdr) begin
              r_err[c_err_unknown] <= 1'b1;
            end
          end
        end
        S_PACK: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_TRAILER: begin
          // An idle cycle separates a flushed half-word from the trailer
          if (!r_valid) begin
            r_data_out <= w_trailer;
            r_valid    <= 1'b1;
            r_evt_len  <= w_evt_next;
          end else if (w_accept) begin
            r_valid <= 1'b0;
            if (r_half_vld) begin
              r_half_vld <= 1'b0;
            end else begin
              r_complete <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.data_out          = r_data_out;
  assign io_bus.data_valid        = r_valid;
  assign io_bus.fifo_rd_en        = r_rd_en;
  assign io_bus.transmit_complete = r_complete;
  assign io_bus.busy              = r_busy;
  assign io_bus.err_flags         = r_err_flags;

endmodule
`default_nettype wire

// File: tb/tb_tdc_event_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_event_packer
// Description : Directed self-checking bench; NUM_TDC=1, MAX_WORDS=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_event_packer;

  localparam logic [63:0] c_h1 = 64'hAA12_3456_ABC0_0A20;
  localparam logic [63:0] c_h3 = 64'hAA00_0001_FFF0_0A20;

  logic clk;
  logic rst;
  tdc_event_packer_if bus ();

  tdc_event_packer #(
    .NUM_TDC   (1),
    .MAX_WORDS (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // FIFO model: main pushes (f_wr), this process pops (f_rd)
  logic [31:0] fmem [0:127];
  logic [6:0]  f_wr = '0;
  logic [6:0]  f_rd = '0;
  logic        f_flush = 1'b0;
  int          underflow = 0;

  assign bus.fifo_empty = (f_rd == f_wr);

  always @(posedge clk) begin
    if (f_flush) begin
      f_rd <= f_wr;
    end else if (bus.fifo_rd_en) begin
      if (f_rd == f_wr) begin
        underflow <= underflow + 1;
      end else begin
        bus.fifo_data <= fmem[f_rd];
        f_rd          <= f_rd + 7'd1;
      end
    end
  end

  task automatic push(input logic [31:0] w);
    fmem[f_wr] = w;
    f_wr       = f_wr + 7'd1;
  endtask

  // Ready driver
  logic       rdy_level = 1'b1;
  logic       tog_mode  = 1'b0;
  logic [3:0] tog_pat   = 4'b1001;
  int         tog_ph    = 0;

  initial begin
    bus.data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_mode) begin
        bus.data_ready = tog_pat[3 - tog_ph];
        tog_ph         = (tog_ph + 1) % 4;
      end else begin
        bus.data_ready = rdy_level;
      end
    end
  end

  // Output collector and stall monitor
  logic [63:0] got[$];
  int          cpl_cnt   = 0;
  int          stall_err = 0;
  int          rd_err    = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && bus.data_out !== prev_data) stall_err++;
        if (bus.data_valid && !bus.data_ready && bus.fifo_rd_en) rd_err++;
        if (bus.data_valid && bus.data_ready) got.push_back(bus.data_out);
        if (bus.transmit_complete) cpl_cnt++;
        prev_stall = bus.data_valid && !bus.data_ready;
        prev_data  = bus.data_out;
      end
    end
  end

  int got_base = 0;
  int cpl0     = 0;

  task automatic run_event(input logic [31:0] acq, input logic [31:0] orb);
    bus.acquisition_counter = acq;
    bus.orbit_number        = orb;
    got_base                = got.size();
    cpl0                    = cpl_cnt;
    bus.transmit_request    = 1'b1;
    @(negedge clk);
    bus.transmit_request    = 1'b0;
    chk("busy_start", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 600 && cpl_cnt == cpl0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("complete_pulses", 64'(cpl_cnt - cpl0), 64'd1);
    chk("busy_end", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_stream(input string tag, input logic [63:0] exp[$]);
    chk({tag, "_len"}, 64'(got.size() - got_base), 64'(exp.size()));
    foreach (exp[i]) begin
      chk($sformatf("%s_w%0d", tag, i),
          (got_base + i < got.size()) ? got[got_base + i] : 64'h0, exp[i]);
    end
  endtask

  logic [63:0] exp_q[$];

  initial begin
    rst                     = 1'b1;
    bus.transmit_request    = 1'b0;
    bus.acquisition_counter = '0;
    bus.orbit_number        = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", bus.data_out, 64'd0);
    chk("rst_valid", 64'(bus.data_valid), 64'd0);
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("rst_complete", 64'(bus.transmit_complete), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two hits, one payload word
    push(32'h1000_0000); push(32'h4000_0001); push(32'h5000_0002); push(32'h3000_0000);
    run_event(32'h0012_3456, 32'h0000_0ABC);
    exp_q = {c_h1, 64'h4000_0001_5000_0002, 64'h5000_0003_0002_0000};
    check_stream("basic", exp_q);

    // Odd hit count: padded second word
    push(32'h1000_0000); push(32'h4000_0011); push(32'h4000_0022); push(32'h4000_0033);
    push(32'h3000_0000);
    run_event(32'h0012_3456, 32'h0000_0ABC);
    exp_q = {c_h1, 64'h4000_0011_4000_0022, 64'h4000_0033_FFFF_FFFF, 64'h5000_0004_0003_0000};
    check_stream("odd", exp_q);

    // Back-pressure pattern 1-0-0-1
    tog_mode = 1'b1;
    push(32'h1000_0000); push(32'h4000_00A1); push(32'h5000_00A2); push(32'h4000_00A3);
    push(32'h5000_00A4); push(32'h3000_0000);
    run_event(32'hFF00_0001, 32'h1234_5FFF);
    tog_mode = 1'b0;
    exp_q = {c_h3, 64'h4000_00A1_5000_00A2, 64'h4000_00A3_5000_00A4, 64'h5000_0004_0004_0000};
    check_stream("bp", exp_q);
    chk("bp_stable", 64'(stall_err), 64'd0);
    chk("bp_no_read", 64'(rd_err), 64'd0);

    // Truncation at MAX_WORDS=4
    push(32'h1000_0000);
    for (int i = 1; i <= 6; i++) push(32'h5000_0000 | 32'(i));
    push(32'h3000_0000);
    run_event(32'h0012_3456, 32'h0000_0ABC);
    exp_q = {c_h1, 64'h5000_0001_5000_0002, 64'h5000_0003_5000_0004, 64'h5000_0004_4004_0000};
    check_stream("trunc", exp_q);
    chk("trunc_drained", 64'(f_rd == f_wr), 64'd1);

    // Unknown code plus TDC error word
    push(32'h1000_0000); push(32'hF000_0000); push(32'h6000_0003); push(32'h4000_0044);
    push(32'h3000_0000);
    run_event(32'h0012_3456, 32'h0000_0ABC);
    exp_q = {c_h1, 64'h6000_0003_4000_0044, 64'h5000_0003_3002_0000};
    check_stream("err", exp_q);
    chk("err_flags", 64'(bus.err_flags), 64'h3);

    // Reset while a payload word is stalled in PACK
    push(32'h1000_0000); push(32'h4000_0001); push(32'h5000_0002); push(32'h3000_0000);
    bus.acquisition_counter = 32'h0012_3456;
    bus.orbit_number        = 32'h0000_0ABC;
    got_base                = got.size();
    cpl0                    = cpl_cnt;
    bus.transmit_request    = 1'b1;
    @(negedge clk);
    bus.transmit_request    = 1'b0;
    for (int i = 0; i < 100 && got.size() == got_base; i++) @(negedge clk);
    rdy_level = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100 && !bus.data_valid; i++) @(negedge clk);
    chk("pack_valid", 64'(bus.data_valid), 64'd1);
    chk("pack_word", bus.data_out, 64'h4000_0001_5000_0002);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data_out", bus.data_out, 64'd0);
    chk("mid_rst_valid", 64'(bus.data_valid), 64'd0);
    chk("mid_rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    chk("mid_rst_words", 64'(got.size() - got_base), 64'd1);
    chk("mid_rst_no_cpl", 64'(cpl_cnt - cpl0), 64'd0);
    f_flush = 1'b1;
    @(negedge clk);
    f_flush   = 1'b0;
    rdy_level = 1'b1;
    repeat (2) @(negedge clk);
    push(32'h1000_0000); push(32'h4000_0001); push(32'h5000_0002); push(32'h3000_0000);
    run_event(32'h0012_3456, 32'h0000_0ABC);
    exp_q = {c_h1, 64'h4000_0001_5000_0002, 64'h5000_0003_0002_0000};
    check_stream("post_rst", exp_q);

    chk("fifo_underflow", 64'(underflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdc_event_packer.md
Name: tdc_event_packer

Overview:
- Builds one DAQ event from HPTDC 32-bit words held in the readout FIFO.
- Emits a stream of 64-bit words: header, packed payload, trailer.
- Sits between the TDC readout FIFO and the serial/optical transmitter.
- Generalises the single-shot frame builder: parametrised depth, TDC count and hit limit; adds output back-pressure, event delimiting, truncation and error accounting.

Parameters:
- TRIGGER_TYPE, 4'hA, header trigger-type field
- FEC_ID, 12'd10, front-end card ID in header
- FOV, 4'd2, format version in header
- NUM_TDC, 4, TDCs per event; event closes after NUM_TDC TDC-trailer words
- MAX_WORDS, 1024, cap on TDC words accepted per event (power of 2, ≤4096)
- CNT_W, 12, width of internal word counters (≥ log2(MAX_WORDS)+1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- transmit_request  in  1  start one event; level, sampled in IDLE only
- orbit_number  in  32  latched at start; low 12 bits used as BX
- acquisition_counter  in  32  latched at start; low 24 bits used as LV1
- fifo_empty  in  1  readout FIFO empty
- fifo_rd_en  out  1  FIFO pop; data valid the following cycle
- fifo_data  in  32  FIFO read data
- data_out  out  64  output word
- data_valid  out  1  data_out valid
- data_ready  in  1  downstream accepts word when valid & ready
- transmit_complete  out  1  one-cycle pulse after trailer accepted
- busy  out  1  high from start until transmit_complete

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters, flags and the half-word register clear.
- Reset mid-event: same as reset; the partial event is discarded with no trailer.
- FSM states: IDLE, HEADER, FETCH, PACK, TRAILER, DONE.
- IDLE -> HEADER on transmit_request; latch LV1 and BX; busy=1.
- HEADER:
  - data_out = {4'hA, TRIGGER_TYPE, LV1[23:0], BX[11:0], FEC_ID, FOV, 1'b0 H, 1'b0, 2'b00}.
  - Hold data_out and data_valid until data_ready; then go to FETCH.
- FETCH:
  - Assert fifo_rd_en for one cycle only when fifo_empty=0 and no unconsumed read is pending.
  - At most one read outstanding.
  - The word arrives the next cycle and is classified by fifo_data[31:28]:
    - 0001 TDC header: counted, not forwarded.
    - 0100 leading / 0101 trailing: forwarded into PACK.
    - 0110 error: forwarded; sets err[0]; also ORs bits [14:0] into a sticky error register.
    - 0011 TDC trailer: increments tdc_done. When tdc_done==NUM_TDC -> TRAILER.
    - Any other code: dropped; sets err[1].
- PACK:
  - Two forwarded words form one 64-bit word: first word in [63:32], second in [31:0].
  - Present the word with valid/ready; return to FETCH after acceptance.
  - A leftover odd word is flushed on entry to TRAILER with [31:0]=32'hFFFF_FFFF.
- Truncation: when MAX_WORDS words have been forwarded, further hit words are read and discarded (FIFO keeps draining) and err[2] is set.
- TRAILER:
  - data_out = {4'h5, 4'h0, evt_len[23:0], err[3:0], hit_cnt[11:0], crc_or_zero[15:0]}.
  - evt_len = 64-bit words including header and trailer.
- DONE: transmit_complete=1 for one cycle; busy=0; -> IDLE. A request held high starts the next event one cycle later.
- Back-pressure: data_out stable while data_valid & !data_ready; no FIFO reads issued while an output word is stalled.
- Counters saturate at their maximum; they never wrap.
- fifo_empty during FETCH: wait indefinitely; no timeout.

Optional Feature:
- Macro: TDC_EVENT_PACKER_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) computed over every 64-bit word emitted from header to last payload word. The result goes in trailer [15:0]. Adds no cycles.
- Undefined: trailer [15:0] = 16'h0000; no CRC logic.

Decomposition:
- Package tdc_pkg:
  - word-type codes 0001/0011/0100/0101/0110
  - header marker 4'hA, trailer marker 4'h5, pad word 32'hFFFF_FFFF
  - FSM state enum
  - err bit indices
- Sub-module crc16_64: one 64-bit word per cycle, with clear and enable. Instantiated only under TDC_EVENT_PACKER_CRC_EN.

Test Plan:
- NUM_TDC=1; FIFO holds {hdr, 0x4000_0001, 0x5000_0002, trl}; ready=1 -> output hdr, 0x4000_0001_5000_0002, trailer with evt_len=3, hit_cnt=2, err=0; transmit_complete pulse.
- Odd hits: three leading words -> second payload word [31:0]=FFFF_FFFF; evt_len=4; hit_cnt=3.
- data_ready toggled 1-0-0-1 every cycle -> data_out stable while stalled; no word lost or duplicated; fifo_rd_en never high during a stall.
- MAX_WORDS=4 with 6 hits -> 2 payload words; err[2]=1; FIFO fully drained through the TDC trailer.
- Unknown type 0xF word plus error word 0x6000_0003 -> err=4'b0011; the error word is packed in the payload.
- rst asserted during PACK -> all outputs 0 the next cycle; no trailer emitted; a new request produces a clean header.
